// File: rtl/serial_borrow_subtractor.sv
// serial_borrow_subtractor
// Bit-serial unsigned subtractor: Diff = A - B (mod 2^WIDTH), with borrow-out.
// One bit is processed per clock, LSB first. Operands are captured on start,
// and the result registers only change on completion.
module serial_borrow_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_n;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             bit_i;
    logic             bit_j;
    logic             bit_d;
    logic             br_n;
    logic             last_bit;

    // One full-subtractor slice working on the current LSBs of the operand shifters.
    always_comb begin
        bit_i    = a_sh[0];
        bit_j    = b_sh[0];
        bit_d    = bit_i ^ bit_j ^ br;
        br_n     = (~bit_i & bit_j) | (~(bit_i ^ bit_j) & br);
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    // Holds the control state; reset drops straight back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic: start is only honoured in IDLE, DONE always lasts one cycle.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (last_bit) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: capture operands, shift one bit per RUN cycle, publish result on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            d_sh <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            Diff <= '0;
            Bout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= A;
                        b_sh <= B;
                        br   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    d_sh <= {bit_d, d_sh[WIDTH-1:1]};
                    br   <= br_n;
                    cnt  <= cnt + CW'(1);
                    if (last_bit) begin
                        Diff <= {bit_d, d_sh[WIDTH-1:1]};
                        Bout <= br_n;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status flags are plain decodes of the state register, so they never glitch.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

endmodule
